// File: rtl/naive_bus_arbiter.sv
// naive_bus_arbiter: shares one naive_bus slave port between two core masters.
// m0 = data master (MEM stage), m1 = instruction master (IF stage).
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mX_rd_req / mX_wr_req           master read / write requests (X = 0, 1)
//   mX_addr, mX_wr_data, mX_wr_be   master address, write data, byte enables
//   mX_rd_gnt / mX_wr_gnt           grants returned to each master
//   mX_rd_data                      read data, valid the cycle after mX_rd_gnt
//   s_rd_req, s_wr_req              requests forwarded to the slave
//   s_addr, s_wr_data, s_wr_be      forwarded address, write data, byte enables
//   s_rd_gnt, s_wr_gnt              slave grants (combinational, same cycle)
//   s_rd_data                       slave read data, valid the cycle after s_rd_gnt
//
// Parameters:
//   RR_MODE      0 = m0 priority with m1 starvation guard, 1 = round-robin
//   STARVE_LIMIT lost cycles after which m1 is forced to win (1..15)

module naive_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_rd_req,
    input  logic                m0_wr_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wr_data,
    input  logic [DATA_W/8-1:0] m0_wr_be,
    output logic                m0_rd_gnt,
    output logic                m0_wr_gnt,
    output logic [DATA_W-1:0]   m0_rd_data,

    input  logic                m1_rd_req,
    input  logic                m1_wr_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wr_data,
    input  logic [DATA_W/8-1:0] m1_wr_be,
    output logic                m1_rd_gnt,
    output logic                m1_wr_gnt,
    output logic [DATA_W-1:0]   m1_rd_data,

    output logic                s_rd_req,
    output logic                s_wr_req,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wr_data,
    output logic [DATA_W/8-1:0] s_wr_be,
    input  logic                s_rd_gnt,
    input  logic                s_wr_gnt,
    input  logic [DATA_W-1:0]   s_rd_data
);

    localparam int BE_W = DATA_W / 8;

    // registered state
    logic       r_rd_vld;
    logic       r_rd_id;
    logic       r_last_win;
    logic [3:0] r_starve;

    // combinational
    logic       w_req0;
    logic       w_req1;
    logic       w_sel_vld;
    logic       w_sel_id;
    logic       w_starved;
    logic       w_sel_rd;
    logic       w_sel_wr;
    logic       w_rd_fire;
    logic       w_wr_fire;
    logic       w_fire;
    logic [3:0] w_starve_nxt;

    assign w_req0    = m0_rd_req | m0_wr_req;
    assign w_req1    = m1_rd_req | m1_wr_req;
    assign w_starved = (r_starve >= 4'(STARVE_LIMIT));

    // Winner selection. last_win only moves on granted transfers, so a
    // stalled winner is picked again next cycle in round-robin mode.
    always_comb begin
        w_sel_vld = w_req0 | w_req1;
        w_sel_id  = 1'b0;
        if (w_req0 && w_req1) begin
            if (RR_MODE != 0) begin
                w_sel_id = ~r_last_win;
            end else begin
                w_sel_id = w_starved;
            end
        end else begin
            w_sel_id = w_req1;
        end
    end

    // Request forwarding from the selected master; rd beats wr.
    always_comb begin
        w_sel_rd  = 1'b0;
        w_sel_wr  = 1'b0;
        s_addr    = '0;
        s_wr_data = '0;
        s_wr_be   = '0;
        if (w_sel_vld) begin
            if (w_sel_id) begin
                w_sel_rd  = m1_rd_req;
                w_sel_wr  = m1_wr_req & ~m1_rd_req;
                s_addr    = m1_addr;
                s_wr_data = m1_wr_data;
                s_wr_be   = m1_wr_be;
            end else begin
                w_sel_rd  = m0_rd_req;
                w_sel_wr  = m0_wr_req & ~m0_rd_req;
                s_addr    = m0_addr;
                s_wr_data = m0_wr_data;
                s_wr_be   = m0_wr_be;
            end
        end
    end

    assign s_rd_req  = w_sel_rd;
    assign s_wr_req  = w_sel_wr;

    assign w_rd_fire = w_sel_rd & s_rd_gnt;
    assign w_wr_fire = w_sel_wr & s_wr_gnt;
    assign w_fire    = w_rd_fire | w_wr_fire;

    assign m0_rd_gnt = w_rd_fire & ~w_sel_id;
    assign m1_rd_gnt = w_rd_fire &  w_sel_id;
    assign m0_wr_gnt = w_wr_fire & ~w_sel_id;
    assign m1_wr_gnt = w_wr_fire &  w_sel_id;

    // m1 loses whenever it asks and is not granted, including slave stalls.
    always_comb begin
        w_starve_nxt = 4'd0;
        if (w_req1 && !(w_fire && w_sel_id)) begin
            if (r_starve == 4'hF) begin
                w_starve_nxt = r_starve;
            end else begin
                w_starve_nxt = r_starve + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_id    <= 1'b0;
            r_last_win <= 1'b1;
            r_starve   <= 4'd0;
        end else begin
            r_rd_vld <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_id <= w_sel_id;
            end
            if (w_fire) begin
                r_last_win <= w_sel_id;
            end
            r_starve <= w_starve_nxt;
        end
    end

    // Read return is a pure mux steered by last cycle's read owner.
    assign m0_rd_data = (r_rd_vld && !r_rd_id) ? s_rd_data : '0;
    assign m1_rd_data = (r_rd_vld &&  r_rd_id) ? s_rd_data : '0;

    logic [BE_W-1:0] w_be_unused;
    assign w_be_unused = '0;

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Bench for naive_bus_arbiter: priority instance (RR_MODE=0) and
// round-robin instance (RR_MODE=1) driven by the same masters.

module tb_naive_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
    logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
    logic [3:0]  m0_wr_be, m1_wr_be;
    logic        rd_en, wr_en;
    logic [31:0] s_rd_data;

    logic        p_m0_rd_gnt, p_m0_wr_gnt, p_m1_rd_gnt, p_m1_wr_gnt;
    logic [31:0] p_m0_rd_data, p_m1_rd_data;
    logic        p_s_rd_req, p_s_wr_req, p_s_rd_gnt, p_s_wr_gnt;
    logic [31:0] p_s_addr, p_s_wr_data;
    logic [3:0]  p_s_wr_be;

    logic        r_m0_rd_gnt, r_m0_wr_gnt, r_m1_rd_gnt, r_m1_wr_gnt;
    logic [31:0] r_m0_rd_data, r_m1_rd_data;
    logic        r_s_rd_req, r_s_wr_req, r_s_rd_gnt, r_s_wr_gnt;
    logic [31:0] r_s_addr, r_s_wr_data;
    logic [3:0]  r_s_wr_be;

    // slave model: grants only what is requested, when enabled
    assign p_s_rd_gnt = p_s_rd_req & rd_en;
    assign p_s_wr_gnt = p_s_wr_req & wr_en;
    assign r_s_rd_gnt = r_s_rd_req & rd_en;
    assign r_s_wr_gnt = r_s_wr_req & wr_en;

    naive_bus_arbiter #(.RR_MODE(0), .STARVE_LIMIT(4)) u_pri (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_wr_be(m0_wr_be),
        .m0_rd_gnt(p_m0_rd_gnt), .m0_wr_gnt(p_m0_wr_gnt), .m0_rd_data(p_m0_rd_data),
        .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_wr_be(m1_wr_be),
        .m1_rd_gnt(p_m1_rd_gnt), .m1_wr_gnt(p_m1_wr_gnt), .m1_rd_data(p_m1_rd_data),
        .s_rd_req(p_s_rd_req), .s_wr_req(p_s_wr_req), .s_addr(p_s_addr),
        .s_wr_data(p_s_wr_data), .s_wr_be(p_s_wr_be),
        .s_rd_gnt(p_s_rd_gnt), .s_wr_gnt(p_s_wr_gnt), .s_rd_data(s_rd_data)
    );

    naive_bus_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_wr_be(m0_wr_be),
        .m0_rd_gnt(r_m0_rd_gnt), .m0_wr_gnt(r_m0_wr_gnt), .m0_rd_data(r_m0_rd_data),
        .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_wr_be(m1_wr_be),
        .m1_rd_gnt(r_m1_rd_gnt), .m1_wr_gnt(r_m1_wr_gnt), .m1_rd_data(r_m1_rd_data),
        .s_rd_req(r_s_rd_req), .s_wr_req(r_s_wr_req), .s_addr(r_s_addr),
        .s_wr_data(r_s_wr_data), .s_wr_be(r_s_wr_be),
        .s_rd_gnt(r_s_rd_gnt), .s_wr_gnt(r_s_wr_gnt), .s_rd_data(s_rd_data)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t q[$];
    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        m0_rd_req = 0; m0_wr_req = 0; m0_addr = 0; m0_wr_data = 0; m0_wr_be = 0;
        m1_rd_req = 0; m1_wr_req = 0; m1_addr = 0; m1_wr_data = 0; m1_wr_be = 0;
        rd_en = 0; wr_en = 0;
    endtask

    // cycle start: slave returns data for last cycle's granted read
    task automatic cyc();
        @(negedge clk);
        s_rd_data = (q.size() > 0) ? q[0].data : $urandom();
    endtask

    task automatic push_rd(input logic id);
        rd_exp_t e;
        e.id   = id;
        e.data = $urandom() | 32'h1;
        q.push_back(e);
    endtask

    task automatic do_reset();
        q.delete();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        m0_rd_req = 1; m0_addr = 32'h44; rd_en = 1;
        #1;
        checks++;
        if (p_s_rd_req !== 1'b1 || p_s_addr !== 32'h44 || p_m0_rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: rd_req=%b addr=%h gnt=%b expected 1/00000044/1",
                     p_s_rd_req, p_s_addr, p_m0_rd_gnt);
        end
        @(negedge clk);
        clear_inputs();
        s_rd_data = 32'h5555AAAA;
        #1;
        checks++;
        if (p_m0_rd_data !== 32'h0 || p_m1_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_data: m0=%h m1=%h expected 0/0", p_m0_rd_data, p_m1_rd_data);
        end
        checks++;
        if (p_s_rd_req !== 1'b0 || p_s_wr_req !== 1'b0 || p_s_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: rd=%b wr=%b addr=%h expected 0/0/0",
                     p_s_rd_req, p_s_wr_req, p_s_addr);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_read();
        rd_exp_t e;
        do_reset();
        cyc();
        m1_rd_req = 1; m1_addr = 32'h0000_0100; rd_en = 1;
        #1;
        checks++;
        if (p_m1_rd_gnt !== 1'b1 || p_m0_rd_gnt !== 1'b0 || p_s_addr !== 32'h100 || p_s_rd_req !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: m1_gnt=%b m0_gnt=%b addr=%h rd=%b expected 1/0/00000100/1",
                     p_m1_rd_gnt, p_m0_rd_gnt, p_s_addr, p_s_rd_req);
        end
        e.id = 1; e.data = 32'hDEADBEEF;
        q.push_back(e);
        cyc();
        clear_inputs();
        #1;
        e = q.pop_front();
        checks++;
        if (p_m1_rd_data !== 32'hDEADBEEF || p_m0_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL single_data: m1=%h m0=%h expected deadbeef/0", p_m1_rd_data, p_m0_rd_data);
        end
    endtask

    task automatic test_priority();
        rd_exp_t e;
        logic w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i < 15) begin
                m0_rd_req = 1; m0_addr = 32'h1000;
                m1_rd_req = 1; m1_addr = 32'h2000;
                rd_en = 1;
            end else begin
                clear_inputs();
            end
            #1;
            checks++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (p_m0_rd_data !== (e.id ? 32'h0 : e.data) ||
                    p_m1_rd_data !== (e.id ? e.data : 32'h0)) begin
                    errors++;
                    $display("FAIL prio_rd_data cyc%0d: m0=%h m1=%h expected id=%0d data=%h",
                             i, p_m0_rd_data, p_m1_rd_data, e.id, e.data);
                end
            end else if (p_m0_rd_data !== 32'h0 || p_m1_rd_data !== 32'h0) begin
                errors++;
                $display("FAIL prio_rd_idle cyc%0d: m0=%h m1=%h expected 0/0",
                         i, p_m0_rd_data, p_m1_rd_data);
            end
            if (i < 15) begin
                w = ((i % 5) == 4);
                checks++;
                if (p_m0_rd_gnt !== ~w || p_m1_rd_gnt !== w ||
                    p_s_addr !== (w ? 32'h2000 : 32'h1000)) begin
                    errors++;
                    $display("FAIL prio_grant cyc%0d: m0=%b m1=%b addr=%h expected winner m%0d",
                             i, p_m0_rd_gnt, p_m1_rd_gnt, p_s_addr, w);
                end
                push_rd(w);
            end
        end
    endtask

    task automatic test_round_robin();
        logic w;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc();
            m0_rd_req = 1; m0_addr = 32'h1000;
            m1_rd_req = 1; m1_addr = 32'h2000;
            rd_en = 1;
            #1;
            w = i[0];
            checks++;
            if (r_m0_rd_gnt !== ~w || r_m1_rd_gnt !== w ||
                r_s_addr !== (w ? 32'h2000 : 32'h1000)) begin
                errors++;
                $display("FAIL rr_grant cyc%0d: m0=%b m1=%b addr=%h expected winner m%0d",
                         i, r_m0_rd_gnt, r_m1_rd_gnt, r_s_addr, w);
            end
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_write_contention();
        rd_exp_t e;
        cyc();
        m0_wr_req = 1; m0_addr = 32'h2000_0004; m0_wr_data = 32'h12345678; m0_wr_be = 4'b0011;
        m1_rd_req = 1; m1_addr = 32'h0000_0100;
        rd_en = 1; wr_en = 1;
        #1;
        checks++;
        if (p_s_wr_req !== 1'b1 || p_s_rd_req !== 1'b0 || p_s_addr !== 32'h2000_0004 ||
            p_s_wr_data !== 32'h12345678 || p_s_wr_be !== 4'b0011) begin
            errors++;
            $display("FAIL wr_forward: wr=%b rd=%b addr=%h data=%h be=%b expected 1/0/20000004/12345678/0011",
                     p_s_wr_req, p_s_rd_req, p_s_addr, p_s_wr_data, p_s_wr_be);
        end
        checks++;
        if (p_m0_wr_gnt !== 1'b1 || p_m1_rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant: m0_wr=%b m1_rd=%b expected 1/0", p_m0_wr_gnt, p_m1_rd_gnt);
        end
        cyc();
        m0_wr_req = 0;
        #1;
        checks++;
        if (p_m1_rd_gnt !== 1'b1 || p_s_addr !== 32'h100 || p_m0_rd_data !== 32'h0 || p_m1_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL wr_then_m1: gnt=%b addr=%h m0d=%h m1d=%h expected 1/00000100/0/0",
                     p_m1_rd_gnt, p_s_addr, p_m0_rd_data, p_m1_rd_data);
        end
        push_rd(1'b1);
        cyc();
        m1_rd_req = 0;
        m0_rd_req = 1; m0_wr_req = 1; m0_addr = 32'h0000_0040;
        #1;
        e = q.pop_front();
        checks++;
        if (p_m1_rd_data !== e.data || p_m0_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL wr_m1_data: m1=%h m0=%h expected %h/0", p_m1_rd_data, p_m0_rd_data, e.data);
        end
        checks++;
        if (p_s_rd_req !== 1'b1 || p_s_wr_req !== 1'b0 || p_m0_rd_gnt !== 1'b1 || p_m0_wr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rd_precedence: rd=%b wr=%b rgnt=%b wgnt=%b expected 1/0/1/0",
                     p_s_rd_req, p_s_wr_req, p_m0_rd_gnt, p_m0_wr_gnt);
        end
        push_rd(1'b0);
        cyc();
        clear_inputs();
        #1;
        e = q.pop_front();
        checks++;
        if (p_m0_rd_data !== e.data || p_m1_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL prec_m0_data: m0=%h m1=%h expected %h/0", p_m0_rd_data, p_m1_rd_data, e.data);
        end
    endtask

    task automatic test_stall();
        rd_exp_t e;
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_rd_req = 1; m0_addr = 32'h3000_0008;
            rd_en = (i == 3);
            #1;
            checks++;
            if (p_s_rd_req !== 1'b1 || p_s_addr !== 32'h3000_0008 ||
                p_m0_rd_gnt !== (i == 3) || p_m1_rd_gnt !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc%0d: rd=%b addr=%h gnt=%b expected 1/30000008/%0d",
                         i, p_s_rd_req, p_s_addr, p_m0_rd_gnt, (i == 3));
            end
            checks++;
            if (p_m0_rd_data !== 32'h0 || p_m1_rd_data !== 32'h0) begin
                errors++;
                $display("FAIL stall_data cyc%0d: m0=%h m1=%h expected 0/0",
                         i, p_m0_rd_data, p_m1_rd_data);
            end
        end
        push_rd(1'b0);
        cyc();
        clear_inputs();
        #1;
        e = q.pop_front();
        checks++;
        if (p_m0_rd_data !== e.data || p_m1_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL stall_return: m0=%h m1=%h expected %h/0", p_m0_rd_data, p_m1_rd_data, e.data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            m0_rd_req = 1; m0_addr = 32'h1000;
            m1_rd_req = 1; m1_addr = 32'h2000;
            rd_en = 1;
            if (i == 4) rst_n = 0;
            #1;
            if (i == 4) begin
                checks++;
                if (p_m1_rd_gnt !== 1'b1 || p_m0_rd_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_grant: m1=%b m0=%b expected 1/0", p_m1_rd_gnt, p_m0_rd_gnt);
                end
            end
        end
        cyc();
        rst_n = 1;
        s_rd_data = 32'hCAFEF00D;
        #1;
        checks++;
        if (p_m1_rd_data !== 32'h0 || p_m0_rd_data !== 32'h0 ||
            r_m1_rd_data !== 32'h0 || r_m0_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_rd_data: p=%h/%h r=%h/%h expected all 0",
                     p_m0_rd_data, p_m1_rd_data, r_m0_rd_data, r_m1_rd_data);
        end
        checks++;
        if (r_m0_rd_gnt !== 1'b1 || r_m1_rd_gnt !== 1'b0 || p_m0_rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_state: rr m0=%b m1=%b prio m0=%b expected 1/0/1",
                     r_m0_rd_gnt, r_m1_rd_gnt, p_m0_rd_gnt);
        end
        cyc();
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        s_rd_data = 0;
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_write_contention();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/naive_bus_arbiter.md
Name: naive_bus_arbiter

Overview:
- Shares one naive_bus slave port between two core masters: m0 = data master (MEM stage), m1 = instruction master (IF stage).
- Selects one requester per cycle and routes its request to the slave.
- Registers which master won each read, so the slave's next-cycle read data returns to the correct master.
- Placed between core_top and the SoC bus router, for memory configurations where instruction and data fetch share one port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enable width = DATA_W/8).
- RR_MODE, 0, arbitration policy: 0 = m0 priority with starvation guard; 1 = strict round-robin.
- STARVE_LIMIT, 4, number of consecutive lost cycles after which m1 is forced to win (RR_MODE=0 only); range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- mX_rd_req  in  1  read request, X = 0, 1.
- mX_wr_req  in  1  write request.
- mX_addr  in  ADDR_W  request address.
- mX_wr_data  in  DATA_W  write data.
- mX_wr_be  in  DATA_W/8  write byte enables.
- mX_rd_gnt  out  1  read grant.
- mX_wr_gnt  out  1  write grant.
- mX_rd_data  out  DATA_W  read data, valid the cycle after mX_rd_gnt.
- s_rd_req, s_wr_req  out  1  slave requests.
- s_addr  out  ADDR_W  slave address.
- s_wr_data  out  DATA_W  slave write data.
- s_wr_be  out  DATA_W/8  slave byte enables.
- s_rd_gnt, s_wr_gnt  in  1  slave grants (combinational, same cycle).
- s_rd_data  in  DATA_W  slave read data, valid the cycle after s_rd_gnt.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. All state updates on the posedge of clk.
- Request definition: reqX = mX_rd_req | mX_wr_req. A master holds rd_req and wr_req mutually exclusive. If both are asserted, rd takes precedence and wr is ignored that cycle.
- Selection (combinational): sel chooses one master per cycle.
  - Only one master requesting: that master wins.
  - Both requesting, RR_MODE=0: m0 wins unless starve_cnt >= STARVE_LIMIT, in which case m1 wins.
  - Both requesting, RR_MODE=1: the master other than last_win wins.
  - Neither requesting: no selection; all s_* request outputs are 0.
- Forwarding: s_* request, address, data and byte-enable outputs come from the selected master only. When nothing is selected, s_addr, s_wr_data and s_wr_be = 0.
- Grants: mX_rd_gnt = (sel==X) & s_rd_gnt; mX_wr_gnt = (sel==X) & s_wr_gnt. A non-selected master sees gnt = 0 and must hold its request unchanged.
- rd_owner register:
  - Set to {valid=1, id=sel} when s_rd_req & s_rd_gnt; otherwise valid=0.
  - Next cycle, m[id]_rd_data = s_rd_data; the other master gets 0.
  - valid=0 → both mX_rd_data = 0.
  - Back-to-back reads to different masters are supported with no bubble.
- last_win register: updated to sel on any granted transaction (read or write). Unchanged when a request is not granted by the slave.
- starve_cnt (4 bits):
  - Increments, saturating at 15, when m1 requests and is not granted.
  - Clears to 0 when m1 is granted or m1 is not requesting.
- Latency: zero added cycles on request and grant paths; read data path is a pure mux with no added delay beyond the slave's one cycle.
- Simultaneous events: slave de-asserts gnt while the winner is held → winner keeps selection (no re-arbitration bias), and starve_cnt still counts for m1 if m1 lost.
- Reset values (rst_n=0 at a posedge):
  - rd_owner.valid=0, rd_owner.id=0, last_win=1 (so m0 wins first in RR mode), starve_cnt=0.
  - All mX_rd_data = 0.
  - Combinational outputs follow inputs during reset.
- Reset mid-operation: a read granted in the cycle reset is applied delivers no data; mX_rd_data = 0 the following cycle.

Test Plan:
1. Reset, then m1_rd_req with addr=0x0000_0100, slave gnt=1 and s_rd_data=0xDEADBEEF next cycle → m1_rd_gnt=1, s_addr=0x100; next cycle m1_rd_data=0xDEADBEEF and m0_rd_data=0.
2. RR_MODE=0: m0 and m1 both continuously read, slave always grants → m0 wins 4 cycles, m1 wins the 5th cycle, pattern repeats; starve_cnt returns to 0 after m1's grant.
3. RR_MODE=1: both master requests held, slave always grants → grants alternate m0, m1, m0, ...; the first grant after reset goes to m0.
4. m0_wr_req with addr=0x2000_0004, data=0x12345678, be=4'b0011, concurrent m1_rd_req → s_wr_req=1 with m0 addr, data and be forwarded; m1_rd_gnt=0; m1 is granted the next cycle.
5. Slave holds s_rd_gnt=0 for 3 cycles on an m0 read → m0_rd_gnt=0 during that time, s_addr stable; on the first gnt=1 cycle the grant goes to m0 and data returns to m0 the following cycle.
6. Read granted to m1, rst_n=0 asserted the same cycle → m1_rd_data=0 next cycle, all state at reset values.
